// File: rtl/button_cmd_debounce.sv
// button_cmd_debounce
//
// Conditions the four raw active-low board push-buttons and turns them into
// counter control commands.
//   - Each raw button is synchronized (two flops) and debounced: a level
//     change is accepted only after DEBOUNCE consecutive synced cycles that
//     disagree with the current debounced level.
//   - Accepted rising/falling edges give one-cycle press / release pulses.
//   - Button 0 gives cmd_reset, button 3 toggles autocount, and buttons 1/2
//     give cmd_up / cmd_down with hold-to-repeat (first repeat after
//     REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles).
//
// Ports
//   clk          in   sole clock, all logic on posedge
//   reset        in   asynchronous, active-high, clears all state
//   button[3:0]  in   raw buttons, active-low, asynchronous to clk
//   btn_level    out  debounced state, 1 = pressed
//   press        out  one-cycle pulse when btn_level[i] rises
//   btn_release  out  one-cycle pulse when btn_level[i] falls
//                     ("release" is a reserved word in SystemVerilog)
//   cmd_reset    out  one-cycle pulse, one cycle after press[0]
//   cmd_up       out  one-cycle pulse(s) from button 1, with repeat
//   cmd_down     out  one-cycle pulse(s) from button 2, with repeat
//   autocount    out  level, toggles one cycle after each press[3]
module button_cmd_debounce #(
    parameter int unsigned      CNT_W         = 24,
    parameter logic [CNT_W-1:0] DEBOUNCE      = 24'd100000,
    parameter logic [CNT_W-1:0] REPEAT_DELAY  = 24'd4000000,
    parameter logic [CNT_W-1:0] REPEAT_PERIOD = 24'd1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] button,
    output logic [3:0] btn_level,
    output logic [3:0] press,
    output logic [3:0] btn_release,
    output logic       cmd_reset,
    output logic       cmd_up,
    output logic       cmd_down,
    output logic       autocount
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE - ONE;
    localparam logic [CNT_W-1:0] RD_LAST = REPEAT_DELAY - ONE;
    localparam logic [CNT_W-1:0] RP_LAST = REPEAT_PERIOD - ONE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       btn_level_q, btn_level_d;
    logic [3:0]       press_q, press_d;
    logic [3:0]       release_q, release_d;
    logic [CNT_W-1:0] db_cnt_q [4];
    logic [CNT_W-1:0] db_cnt_d [4];
    logic             cmd_reset_q, cmd_reset_d;
    logic             autocount_q, autocount_d;
    logic             cmd_up_q, cmd_up_d;
    logic             cmd_down_q, cmd_down_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             owner_dn_q, owner_dn_d;   // 0 = up owns the repeat, 1 = down
    logic             abort;

    // Debounce: count consecutive disagreeing synced cycles; any agreement
    // (a bounce) restarts the count from zero.
    always_comb begin
        btn_level_d = btn_level_q;
        press_d     = '0;
        release_d   = '0;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != btn_level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    btn_level_d[i] = sync2_q[i];
                    press_d[i]     = sync2_q[i];
                    release_d[i]   = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + ONE;
                end
            end
        end
    end

    // Repeat FSM. It looks at btn_level_d (the level committed at the same
    // edge) so an abort caused by a level change suppresses the command that
    // would otherwise be registered alongside that change; this keeps
    // cmd_up/cmd_down low in every cycle where the reset button or the
    // opposing button is seen as held.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        owner_dn_d  = owner_dn_q;
        cmd_up_d    = 1'b0;
        cmd_down_d  = 1'b0;
        cmd_reset_d = press_q[0];
        autocount_d = autocount_q ^ press_q[3];

        abort = btn_level_d[0] |
                (owner_dn_q ? (~btn_level_d[2] | btn_level_d[1])
                            : (~btn_level_d[1] | btn_level_d[2]));

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (!btn_level_d[0]) begin
                    if (press_q[1] && !press_q[2] && !btn_level_d[2]) begin
                        cmd_up_d   = 1'b1;
                        owner_dn_d = 1'b0;
                        state_d    = ST_DELAY;
                    end else if (press_q[2] && !press_q[1] && !btn_level_d[1]) begin
                        cmd_down_d = 1'b1;
                        owner_dn_d = 1'b1;
                        state_d    = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == RD_LAST) begin
                    cmd_up_d   = ~owner_dn_q;
                    cmd_down_d = owner_dn_q;
                    state_d    = ST_REPEAT;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + ONE;
                end
            end
            ST_REPEAT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == RP_LAST) begin
                    cmd_up_d   = ~owner_dn_q;
                    cmd_down_d = owner_dn_q;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            btn_level_q <= '0;
            press_q     <= '0;
            release_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            cmd_reset_q <= 1'b0;
            autocount_q <= 1'b0;
            cmd_up_q    <= 1'b0;
            cmd_down_q  <= 1'b0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            owner_dn_q  <= 1'b0;
        end else begin
            sync1_q     <= ~button;
            sync2_q     <= sync1_q;
            btn_level_q <= btn_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            cmd_reset_q <= cmd_reset_d;
            autocount_q <= autocount_d;
            cmd_up_q    <= cmd_up_d;
            cmd_down_q  <= cmd_down_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            owner_dn_q  <= owner_dn_d;
        end
    end

    assign btn_level   = btn_level_q;
    assign press       = press_q;
    assign btn_release = release_q;
    assign cmd_reset   = cmd_reset_q;
    assign cmd_up      = cmd_up_q;
    assign cmd_down    = cmd_down_q;
    assign autocount   = autocount_q;

endmodule

// File: tb/tb_button_cmd_debounce.sv
// Testbench for button_cmd_debounce with DEBOUNCE=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. A behavioural model predicts every output each cycle from
// a history of the raw inputs and the edge index of the first command of a
// hold; directed scenarios add explicit timing checks.
module tb_button_cmd_debounce;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk;
    logic       reset;
    logic [3:0] button;
    logic [3:0] btn_level;
    logic [3:0] press;
    logic [3:0] btn_release;
    logic       cmd_reset;
    logic       cmd_up;
    logic       cmd_down;
    logic       autocount;

    button_cmd_debounce #(
        .CNT_W        (24),
        .DEBOUNCE     (24'd4),
        .REPEAT_DELAY (24'd10),
        .REPEAT_PERIOD(24'd3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button     (button),
        .btn_level  (btn_level),
        .press      (press),
        .btn_release(btn_release),
        .cmd_reset  (cmd_reset),
        .cmd_up     (cmd_up),
        .cmd_down   (cmd_down),
        .autocount  (autocount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] raw_hist [0:8191];   // pressed (active-high) value present at each edge
    int         ecnt     = 0;        // index of the most recent edge
    int         rst_edge = 0;        // last edge seen with reset asserted
    logic [3:0] m_lvl, m_press, m_rel;
    logic       m_creset, m_up, m_dn, m_auto;
    logic       m_active, m_own;     // m_own: 0 = up, 1 = down
    int         m_start;             // edge of the first command of the current hold

    task automatic model_clear();
        m_lvl = '0; m_press = '0; m_rel = '0;
        m_creset = 1'b0; m_up = 1'b0; m_dn = 1'b0; m_auto = 1'b0;
        m_active = 1'b0; m_own = 1'b0; m_start = 0;
    endtask

    // Synchronizer contents are cleared by reset, so samples from before the
    // last reset edge read as released.
    function automatic logic [3:0] samp(input int m);
        if (m < 0 || m <= rst_edge) return 4'b0;
        return raw_hist[m];
    endfunction

    task automatic model_edge(input logic [3:0] pressed);
        logic [3:0] pp, np, nr, s;
        logic       ok;
        int         k, own_i, oth_i;
        ecnt++;
        if (reset) begin
            raw_hist[ecnt] = '0;
            rst_edge = ecnt;
            model_clear();
            return;
        end
        raw_hist[ecnt] = pressed;
        pp = m_press; np = '0; nr = '0;
        // A level flips at edge n when the DB synced samples feeding edges
        // n-DB+1..n all disagree with it; the synced value before edge n is
        // the raw value present at edge n-2.
        for (int i = 0; i < 4; i++) begin
            ok = 1'b1;
            for (int j = 0; j < DB; j++) begin
                s = samp(ecnt - 2 - j);
                if (s[i] == m_lvl[i]) ok = 1'b0;
            end
            if (ok) begin
                if (m_lvl[i]) nr[i] = 1'b1; else np[i] = 1'b1;
                m_lvl[i] = ~m_lvl[i];
            end
        end
        m_press  = np;
        m_rel    = nr;
        m_creset = pp[0];
        if (pp[3]) m_auto = ~m_auto;
        m_up = 1'b0; m_dn = 1'b0;
        if (m_active) begin
            own_i = m_own ? 2 : 1;
            oth_i = m_own ? 1 : 2;
            if (m_lvl[0] || !m_lvl[own_i] || m_lvl[oth_i]) begin
                m_active = 1'b0;
            end else begin
                k = ecnt - m_start;
                if (k >= RD && ((k - RD) % RP) == 0) begin
                    if (m_own) m_dn = 1'b1; else m_up = 1'b1;
                end
            end
        end else if (!m_lvl[0]) begin
            if (pp[1] && !pp[2] && !m_lvl[2]) begin
                m_active = 1'b1; m_own = 1'b0; m_start = ecnt; m_up = 1'b1;
            end else if (pp[2] && !pp[1] && !m_lvl[1]) begin
                m_active = 1'b1; m_own = 1'b1; m_start = ecnt; m_dn = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("btn_level", 32'(btn_level), 32'(m_lvl));
        chk("press", 32'(press), 32'(m_press));
        chk("release", 32'(btn_release), 32'(m_rel));
        chk("cmd_reset", 32'(cmd_reset), 32'(m_creset));
        chk("cmd_up", 32'(cmd_up), 32'(m_up));
        chk("cmd_down", 32'(cmd_down), 32'(m_dn));
        chk("autocount", 32'(autocount), 32'(m_auto));
        chk("up_down_excl", 32'(cmd_up & cmd_down), 0);
    endtask

    // Called at a negedge: drive, take one posedge, compare, return at negedge.
    task automatic step(input logic [3:0] raw_n);
        button = raw_n;
        @(posedge clk);
        model_edge(~raw_n);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] raw_n, input int n);
        for (int c = 0; c < n; c++) step(raw_n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("async_rst_outs",
            32'({btn_level, press, btn_release, cmd_reset, cmd_up, cmd_down, autocount}), 0);
        model_clear();
        @(posedge clk);
        model_edge(~button);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    int   e0, p_edge, t_edge, cnt_a, cnt_b, cnt_c, p0;
    int   up_q[$];
    int   cr_q[$];
    int   exp_up[4];
    logic flag, ac_prev;
    logic [3:0] raw;

    initial begin
        reset  = 1'b1;
        button = 4'hF;
        model_clear();
        @(negedge clk);
        hold(4'hF, 3);
        reset = 1'b0;
        hold(4'hF, 4);

        // Clean press of up: raw change before edge 0.
        e0 = ecnt + 1;
        p_edge = -1;
        up_q.delete();
        for (int c = 0; c < 25; c++) begin
            step(4'hD);
            if (cmd_up) up_q.push_back(ecnt - e0);
            if (press[1]) p_edge = ecnt - e0;
        end
        chk("clean_press_edge", p_edge, 5);
        chk("clean_up_count", up_q.size(), 4);
        exp_up = '{6, 16, 19, 22};
        for (int i = 0; i < 4; i++)
            if (i < up_q.size()) chk("clean_up_edge", up_q[i], exp_up[i]);
        cnt_a = 0; cnt_b = 0; flag = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(4'hF);
            if (btn_release[1]) begin cnt_a++; flag = 1'b1; end
            if (flag && cmd_up) cnt_b++;
        end
        chk("clean_release_count", cnt_a, 1);
        chk("clean_up_after_release", cnt_b, 0);

        // Bounce: toggle every 2 cycles for 20 cycles, then hold pressed.
        cnt_a = 0; p_edge = -1;
        for (int c = 0; c < 20; c++) begin
            step(((c / 2) % 2) != 0 ? 4'hF : 4'hD);
            if (press[1]) cnt_a++;
        end
        t_edge = ecnt + 1;
        for (int c = 0; c < 15; c++) begin
            step(4'hD);
            if (press[1]) begin cnt_a++; p_edge = ecnt - t_edge; end
        end
        chk("bounce_press_count", cnt_a, 1);
        chk("bounce_press_edge", p_edge, 1 + DB);
        hold(4'hF, 12);

        // Conflict: up in REPEAT, then down joins.
        hold(4'hD, 22);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int c = 0; c < 15; c++) begin
            step(4'h9);
            if (btn_level[1] && btn_level[2] && (cmd_up || cmd_down)) cnt_a++;
        end
        for (int c = 0; c < 10; c++) begin
            step(4'hB);
            if (btn_level[1] && btn_level[2] && (cmd_up || cmd_down)) cnt_a++;
            if (cmd_down || cmd_up) cnt_b++;
        end
        hold(4'hF, 8);
        for (int c = 0; c < 8; c++) begin
            step(4'hB);
            if (cmd_down) cnt_c++;
        end
        chk("conflict_both_held_cmd", cnt_a, 0);
        chk("conflict_no_takeover", cnt_b, 0);
        chk("conflict_fresh_down", cnt_c, 1);
        hold(4'hF, 10);

        // Reset priority: up in REPEAT, then reset button.
        hold(4'hD, 22);
        flag = 1'b0; p0 = -1; cnt_a = 0;
        cr_q.delete();
        for (int c = 0; c < 35; c++) begin
            step(c < 20 ? 4'hC : 4'hD);
            if (press[0]) p0 = ecnt;
            if (cmd_reset) cr_q.push_back(ecnt);
            if (btn_level[0]) flag = 1'b1;
            if (flag && cmd_up) cnt_a++;
        end
        chk("rstbtn_cmd_reset_count", cr_q.size(), 1);
        if (cr_q.size() > 0) chk("rstbtn_cmd_reset_edge", cr_q[0], p0 + 1);
        chk("rstbtn_no_up", cnt_a, 0);
        hold(4'hF, 10);
        hold(4'hD, 10);
        hold(4'hF, 10);

        // Autocount: three presses of button 3.
        for (int k = 0; k < 3; k++) begin
            ac_prev = autocount; p_edge = -1; t_edge = -1;
            for (int c = 0; c < 12; c++) begin
                step(c < 6 ? 4'h7 : 4'hF);
                if (press[3]) p_edge = ecnt;
                if (autocount != ac_prev && t_edge < 0) t_edge = ecnt;
            end
            chk("auto_toggle_edge", t_edge, p_edge + 1);
            chk("auto_value", 32'(autocount), (k + 1) % 2);
        end

        // Async reset with the up debounce counter at 2 (autocount is high).
        step(4'hD); step(4'hD); step(4'hD); step(4'hD);
        do_reset();
        t_edge = ecnt + 1; p_edge = -1;
        for (int c = 0; c < 25; c++) begin
            step(4'hD);
            if (press[1]) p_edge = ecnt - t_edge;
        end
        chk("requalify_edge", p_edge, 1 + DB);
        do_reset();          // reset again while up is held in REPEAT
        hold(4'hD, 12);
        hold(4'hF, 10);

        // Randomized phase.
        raw = 4'hF;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 29) == 0) raw[0] = ~raw[0];
            for (int b = 1; b < 4; b++)
                if ($urandom_range(0, 9) == 0) raw[b] = ~raw[b];
            if ($urandom_range(0, 299) == 0) begin
                button = raw;
                do_reset();
            end else begin
                step(raw);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
